// File: rtl/wb_regfile_hilo_pkg.sv
// Shared constants for the write-back register file: GPR geometry, enable
// encodings and the active-low reset levels.
`timescale 1ns/1ps
package wb_regfile_hilo_pkg;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  localparam logic [RegNumLog2-1:0] NOPRegAddr = '0;
  localparam logic [31:0]           ZeroWord   = 32'h0000_0000;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  // Reset is active-low: "enable" means the reset is being applied.
  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

endpackage

// File: rtl/wb_regfile_hilo_hilo.sv
// HI/LO register pair. Both halves are always written together; the output
// is the registered value, with no same-cycle bypass.
`timescale 1ns/1ps
module hilo_reg
  import wb_regfile_hilo_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [DW-1:0] hi_reg;
  logic [DW-1:0] lo_reg;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (we == WriteEnable) begin
      hi_reg <= hi_i;
      lo_reg <= lo_i;
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;

endmodule

// File: rtl/wb_regfile_hilo.sv
// Write-back stage state: 32x32 GPR file with two bypassed combinational read
// ports, the HI/LO pair and a commit counter.
`timescale 1ns/1ps
module wb_regfile_hilo
  import wb_regfile_hilo_pkg::*;
#(
  parameter int NUM_REGS = RegNum,
  parameter int DW       = 32,
  parameter int AW       = RegNumLog2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_wd,
  input  logic          wb_wreg,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_whilo,
  input  logic [DW-1:0] wb_hi,
  input  logic [DW-1:0] wb_lo,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic [31:0]   commit_cnt
);

  logic [DW-1:0] regs [NUM_REGS];
  logic [31:0]   cnt_reg;
  logic [31:0]   cnt_next;

  // The array is deliberately left out of reset; only entry 0 is special and
  // it is never read from storage.
  always_ff @(posedge clk) begin
    if (rst == RstDisable && wb_wreg == WriteEnable && wb_wd != NOPRegAddr) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  logic [1:0]         re_pk;
  logic [1:0][AW-1:0] raddr_pk;

  assign re_pk    = {re2, re1};
  assign raddr_pk = {raddr2, raddr1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DW-1:0] rd_data;

      always_comb begin
        rd_data = '0;
        if (rst == RstEnable) begin
          rd_data = '0;
        end else if (raddr_pk[gi] == NOPRegAddr) begin
          rd_data = '0;
        end else if (re_pk[gi] == ReadEnable && wb_wreg == WriteEnable &&
                     raddr_pk[gi] == wb_wd) begin
          rd_data = wb_wdata;
        end else if (re_pk[gi] == ReadEnable) begin
          rd_data = regs[raddr_pk[gi]];
        end else if (re_pk[gi] == ReadDisable) begin
          rd_data = '0;
        end
      end
    end
  endgenerate

  assign rdata1 = g_rd[0].rd_data;
  assign rdata2 = g_rd[1].rd_data;

  hilo_reg #(
    .DW (DW)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (wb_whilo),
    .hi_i (wb_hi),
    .lo_i (wb_lo),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

  // A cycle counts once whether it writes GPR, HI/LO or both; writes to r0 count too.
  always_comb begin
    cnt_next = cnt_reg;
    if (!(wb_wreg == WriteDisable && wb_whilo == WriteDisable)) begin
      cnt_next = cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_reg <= ZeroWord;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign commit_cnt = cnt_reg;

endmodule
